// File: rtl/multicycle_control.sv
// Control FSM for the multicycle 16-bit datapath: fetch, decode, execute, memory and writeback.
// It stalls on the mem_ready handshake and faults to HALT if memory never answers.
module multicycle_control #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic [3:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       ula_src_a,
    output logic [1:0] ula_src_b,
    output logic [1:0] ula_opcode,
    output logic       halted,
    output logic       bus_error,
    output logic [3:0] state_out
);

    localparam int unsigned CNT_W = 8;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LW   = 4'b0010;
    localparam logic [3:0] OP_SW   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_R   = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] w_stall_next;
    logic             r_is_imm;
    logic             w_is_imm_next;
    logic             r_bus_error;
    logic             w_bus_error_next;
    logic             w_wait_state;
    logic             w_timeout;
    logic             w_unused;

    // The zero flag gates pc_write_cond inside the datapath, not here.
    assign w_unused = zero;

    assign state_out = r_state;
    assign bus_error = r_bus_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_stall     <= '0;
            r_is_imm    <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_stall     <= w_stall_next;
            r_is_imm    <= w_is_imm_next;
            r_bus_error <= w_bus_error_next;
        end
    end

    // Timeout fires on the stall cycle that would bring the counter to WAIT_LIMIT.
    always_comb begin
        w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
        w_timeout    = w_wait_state && !mem_ready && (r_stall == CNT_W'(WAIT_LIMIT - 1));
    end

    always_comb begin
        w_next           = r_state;
        w_stall_next     = '0;
        w_is_imm_next    = r_is_imm;
        w_bus_error_next = r_bus_error;
        pc_write         = 1'b0;
        pc_write_cond    = 1'b0;
        pc_src           = 2'b00;
        ir_write         = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        i_or_d           = 1'b0;
        reg_write        = 1'b0;
        reg_dst          = 1'b0;
        mem_to_reg       = 1'b0;
        ula_src_a        = 1'b0;
        ula_src_b        = 2'b00;
        ula_opcode       = 2'b00;
        halted           = 1'b0;

        if (w_wait_state && !mem_ready && !w_timeout) begin
            w_stall_next = r_stall + CNT_W'(1);
        end

        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                ula_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                ula_src_b = 2'b10;
                case (opcode)
                    OP_R:          w_next = (func == 4'b0000) ? S_JR : S_EXEC_R;
                    OP_ADDI:       w_next = S_EXEC_I;
                    OP_LW, OP_SW:  w_next = S_ADDR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    OP_HALT:       w_next = S_HALT;
                    default:       w_next = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                ula_src_a     = 1'b1;
                ula_opcode    = 2'b10;
                w_is_imm_next = 1'b0;
                w_next        = S_WB_R;
            end
            S_EXEC_I: begin
                ula_src_a     = 1'b1;
                ula_src_b     = 2'b10;
                w_is_imm_next = 1'b1;
                w_next        = S_WB_R;
            end
            S_ADDR: begin
                ula_src_a = 1'b1;
                ula_src_b = 2'b10;
                w_next    = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) w_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = !r_is_imm;
                w_next    = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ula_src_a     = 1'b1;
                ula_opcode    = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                w_next   = S_FETCH;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = 2'b11;
                w_next   = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_IDLE;
        endcase

        if (w_timeout) begin
            w_next           = S_HALT;
            w_bus_error_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle check of multicycle_control: each step queues the expected state and control word
// and compares it against the DUT at the falling edge.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic [3:0] func = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic       reg_write, reg_dst, mem_to_reg, ula_src_a, halted, bus_error;
    logic [1:0] pc_src, ula_src_b, ula_opcode;
    logic [3:0] state_out;
    logic [17:0] w_obs;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctl;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic tb_imm = 1'b0;
    logic tb_berr = 1'b0;

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_LIMIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .ula_src_a(ula_src_a), .ula_src_b(ula_src_b), .ula_opcode(ula_opcode),
        .halted(halted), .bus_error(bus_error), .state_out(state_out)
    );

    assign w_obs = {pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write, i_or_d,
                    reg_write, reg_dst, mem_to_reg, ula_src_a, ula_src_b, ula_opcode,
                    halted, bus_error};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Control word each state must present, straight from the state table.
    function automatic logic [17:0] exp_ctl(input logic [3:0] st, input logic rdy);
        logic pw, pwc, irw, mr, mw, iod, rw, rd, m2r, sa, hl, be;
        logic [1:0] ps, sb, uo;
        {pw, pwc, irw, mr, mw, iod, rw, rd, m2r, sa, hl, be} = '0;
        ps = 2'b00; sb = 2'b00; uo = 2'b00;
        case (st)
            4'd1:  begin mr = 1'b1; sb = 2'b01; if (rdy) begin irw = 1'b1; pw = 1'b1; end end
            4'd2:  sb = 2'b10;
            4'd3:  begin sa = 1'b1; uo = 2'b10; end
            4'd4,
            4'd5:  begin sa = 1'b1; sb = 2'b10; end
            4'd6:  begin mr = 1'b1; iod = 1'b1; end
            4'd7:  begin mw = 1'b1; iod = 1'b1; end
            4'd8:  begin rw = 1'b1; rd = !tb_imm; end
            4'd9:  begin rw = 1'b1; m2r = 1'b1; end
            4'd10: begin sa = 1'b1; uo = 2'b01; pwc = 1'b1; ps = 2'b01; end
            4'd11: begin pw = 1'b1; ps = 2'b10; end
            4'd12: begin pw = 1'b1; ps = 2'b11; end
            4'd13: begin hl = 1'b1; be = tb_berr; end
            default: ;
        endcase
        return {pw, pwc, ps, irw, mr, mw, iod, rw, rd, m2r, sa, sb, uo, hl, be};
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    task automatic step(input logic [3:0] st, input logic rdy);
        exp_t e;
        exp_t o;
        mem_ready = rdy;
        e.st  = st;
        e.ctl = exp_ctl(st, rdy);
        sb_q.push_back(e);
        @(negedge clk);
        o = sb_q.pop_front();
        check($sformatf("state(exp %0d)", o.st), 32'(state_out), 32'(o.st));
        check($sformatf("ctl(state %0d)", o.st), 32'(w_obs), 32'(o.ctl));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_state", 32'(state_out), 32'd0);
        check("reset_ctl", 32'(w_obs), 32'd0);
        tb_berr = 1'b0;
        tb_imm  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic [3:0] fn);
        opcode = op;
        func   = fn;
        step(4'd1, 1'b1);
        step(4'd2, rnd());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset();

        // add
        tb_imm = 1'b0;
        instr(4'b0000, 4'b0010); step(4'd3, rnd()); step(4'd8, rnd());
        // addi
        tb_imm = 1'b1;
        instr(4'b0001, 4'd0); step(4'd4, rnd()); step(4'd8, rnd());
        tb_imm = 1'b0;
        // lw with three stall cycles
        instr(4'b0010, 4'd0); step(4'd5, rnd());
        step(4'd6, 1'b0); step(4'd6, 1'b0); step(4'd6, 1'b0); step(4'd6, 1'b1);
        step(4'd9, rnd());
        // sw
        instr(4'b0011, 4'd0); step(4'd5, rnd()); step(4'd7, 1'b1);
        // jr
        instr(4'b0000, 4'b0000); step(4'd12, rnd());
        // beq with zero set
        zero = 1'b1;
        instr(4'b0100, 4'd0); step(4'd10, rnd());
        zero = 1'b0;
        // j
        instr(4'b0101, 4'd0); step(4'd11, rnd());
        // illegal opcode
        instr(4'b1010, 4'd0);
        // halt after a short fetch stall
        opcode = 4'b1111;
        step(4'd1, 1'b0); step(4'd1, 1'b0);
        instr(4'b1111, 4'd0);
        for (int i = 0; i < 4; i++) step(4'd13, rnd());

        // reset in the middle of a stalled store
        do_reset();
        instr(4'b0011, 4'd0); step(4'd5, rnd()); step(4'd7, 1'b0);
        #2;
        check("mem_write_before_reset", 32'(mem_write), 32'd1);
        do_reset();

        // ready arriving on the last allowed stall cycle still succeeds
        opcode = 4'b1010;
        for (int i = 0; i < 14; i++) step(4'd1, 1'b0);
        step(4'd1, 1'b1);
        step(4'd2, rnd());

        // fetch timeout
        for (int i = 0; i < 15; i++) step(4'd1, 1'b0);
        tb_berr = 1'b1;
        for (int i = 0; i < 3; i++) step(4'd13, rnd());
        check("bus_error_sticky", 32'(bus_error), 32'd1);

        do_reset();
        check("bus_error_cleared", 32'(bus_error), 32'd0);
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
